// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the GPR write-back arbiter slice.
package wb_arb_pkg;

  localparam int unsigned WB_NUM_SRC = 8;
  localparam int unsigned WB_DATA_W  = 32;

  typedef logic [4:0] Gpr_index;

  typedef struct packed {
    Gpr_index               gpr;
    logic [WB_DATA_W-1:0]   data;
  } Wb_entry;

  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 1 == n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Result-bus and GPR write-port bundle between the functional units and the arbiter.
interface wb_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = WB_NUM_SRC,
  parameter int unsigned DATA_W  = WB_DATA_W
);

  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0][4:0]        src_gpr;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]             src_ready;
  logic                           gpr_we;
  Gpr_index                       gpr_waddr;
  logic [DATA_W-1:0]              gpr_wdata;
  logic                           idle;

  modport slave (
    input  src_valid, src_gpr, src_data,
    output src_ready, gpr_we, gpr_waddr, gpr_wdata, idle
  );

  modport master (
    output src_valid, src_gpr, src_data,
    input  src_ready, gpr_we, gpr_waddr, gpr_wdata, idle
  );

endinterface

// File: rtl/wb_arbiter_src_fifo.sv
// Per-source result FIFO holding {gpr, data} entries until the arbiter drains them.
module wb_src_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = WB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  Gpr_index          push_gpr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output Gpr_index          head_gpr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  Gpr_index          gpr_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic do_push;
  logic do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_gpr  = gpr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        gpr_mem[wr_ptr]  <= push_gpr;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Buffers functional-unit results per source and drains them round-robin
// through the single registered GPR write port.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = WB_NUM_SRC,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned DATA_W  = WB_DATA_W
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  Gpr_index           head_gpr  [NUM_SRC];
  logic [DATA_W-1:0]  head_data [NUM_SRC];

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;

  logic               gpr_we_q;
  Gpr_index           gpr_waddr_q;
  logic [DATA_W-1:0]  gpr_wdata_q;

  // Readiness comes from the registered count only, so a full FIFO refuses
  // a push even in the cycle it is being popped.
  assign bus.src_ready = ~full & {NUM_SRC{~reset}};
  assign push          = bus.src_valid & bus.src_ready;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    wb_src_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[i]),
      .push_gpr  (bus.src_gpr[i]),
      .push_data (bus.src_data[i]),
      .pop       (pop[i]),
      .head_gpr  (head_gpr[i]),
      .head_data (head_data[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      int unsigned cand;
      cand = (32'(rr_ptr) + k) % NUM_SRC;
      if (!grant_any && !empty[cand]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    pop            = '0;
    pop[grant_idx] = grant_any;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      gpr_we_q    <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
    end else if (grant_any) begin
      rr_ptr      <= PTR_W'(rr_next(32'(grant_idx), NUM_SRC));
      gpr_we_q    <= 1'b1;
      gpr_waddr_q <= head_gpr[grant_idx];
      gpr_wdata_q <= head_data[grant_idx];
    end else begin
      gpr_we_q    <= 1'b0;
    end
  end

  assign bus.gpr_we    = gpr_we_q;
  assign bus.gpr_waddr = gpr_waddr_q;
  assign bus.gpr_wdata = gpr_wdata_q;
  assign bus.idle      = (&empty) & ~gpr_we_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int unsigned N = 8;
  localparam int unsigned D = 2;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_arbiter_if #(.NUM_SRC(N), .DATA_W(W)) bus ();

  wb_arbiter #(.NUM_SRC(N), .DEPTH(D), .DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: per-source queues of {gpr, data}; source id lives in data[31:28].
  logic [36:0] sbq [N][$];
  bit sb_on = 1'b0;
  int pushed = 0;
  int written = 0;

  task automatic drive(input int unsigned i, input logic v, input logic [4:0] g, input logic [31:0] d);
    bus.src_valid[i] = v;
    bus.src_gpr[i]   = g;
    bus.src_data[i]  = d;
  endtask

  task automatic clear_src();
    for (int unsigned i = 0; i < N; i++) drive(i, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    #1;
    if (sb_on)
      for (int unsigned i = 0; i < N; i++)
        if (bus.src_valid[i] && bus.src_ready[i]) begin
          sbq[i].push_back({bus.src_gpr[i], bus.src_data[i]});
          pushed++;
        end
    @(posedge clk);
    #1;
    if (sb_on && bus.gpr_we) begin
      int unsigned s;
      s = 32'(bus.gpr_wdata[31:28]);
      written++;
      if (s >= N || sbq[s].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got write %0h/%0h expected none", bus.gpr_waddr, bus.gpr_wdata);
      end else begin
        chk("sb_write", {bus.gpr_waddr, bus.gpr_wdata}, sbq[s].pop_front());
      end
    end
  endtask

  task automatic reset_pulse();
    clear_src();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  valid;
    logic [4:0]  gpr_base;
    logic [31:0] data_base;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  ready;
    logic        idle;
  } vec_t;

  vec_t vt [13];

  initial begin
    int seq;
    int last;
    bit saw_low;
    int leftover;

    vt[0]  = '{8'hFF, 5'd8, 32'hA000_0000, 1'b0, 5'd0,  32'h0000_0000, 8'hFF, 1'b0};
    vt[1]  = '{8'h00, 5'd0, 32'h0,         1'b1, 5'd8,  32'hA000_0000, 8'hFF, 1'b0};
    vt[2]  = '{8'h00, 5'd0, 32'h0,         1'b1, 5'd9,  32'hA000_0001, 8'hFF, 1'b0};
    vt[3]  = '{8'h00, 5'd0, 32'h0,         1'b1, 5'd10, 32'hA000_0002, 8'hFF, 1'b0};
    vt[4]  = '{8'h00, 5'd0, 32'h0,         1'b1, 5'd11, 32'hA000_0003, 8'hFF, 1'b0};
    vt[5]  = '{8'h00, 5'd0, 32'h0,         1'b1, 5'd12, 32'hA000_0004, 8'hFF, 1'b0};
    vt[6]  = '{8'h00, 5'd0, 32'h0,         1'b1, 5'd13, 32'hA000_0005, 8'hFF, 1'b0};
    vt[7]  = '{8'h00, 5'd0, 32'h0,         1'b1, 5'd14, 32'hA000_0006, 8'hFF, 1'b0};
    vt[8]  = '{8'h00, 5'd0, 32'h0,         1'b1, 5'd15, 32'hA000_0007, 8'hFF, 1'b0};
    vt[9]  = '{8'h00, 5'd0, 32'h0,         1'b0, 5'd15, 32'hA000_0007, 8'hFF, 1'b1};
    vt[10] = '{8'h08, 5'd4, 32'hDEAD_BEEC, 1'b0, 5'd15, 32'hA000_0007, 8'hFF, 1'b0};
    vt[11] = '{8'h00, 5'd0, 32'h0,         1'b1, 5'd7,  32'hDEAD_BEEF, 8'hFF, 1'b0};
    vt[12] = '{8'h00, 5'd0, 32'h0,         1'b0, 5'd7,  32'hDEAD_BEEF, 8'hFF, 1'b1};

    // Reset state
    clear_src();
    reset = 1'b1;
    tick();
    chk("rst_we",    bus.gpr_we,    1'b0);
    chk("rst_waddr", bus.gpr_waddr, 5'd0);
    chk("rst_wdata", bus.gpr_wdata, 32'd0);
    chk("rst_idle",  bus.idle,      1'b1);
    chk("rst_ready_low", bus.src_ready, 8'h00);
    reset = 1'b0;
    #1;
    chk("rst_ready_high", bus.src_ready, 8'hFF);

    // Vector table: all-sources burst in order, then a single result
    for (int r = 0; r < 13; r++) begin
      for (int unsigned i = 0; i < N; i++)
        drive(i, vt[r].valid[i], vt[r].gpr_base + 5'(i), vt[r].data_base + i);
      tick();
      chk($sformatf("vec%0d_we", r),    bus.gpr_we,    vt[r].we);
      chk($sformatf("vec%0d_waddr", r), bus.gpr_waddr, vt[r].waddr);
      chk($sformatf("vec%0d_wdata", r), bus.gpr_wdata, vt[r].wdata);
      chk($sformatf("vec%0d_ready", r), bus.src_ready, vt[r].ready);
      chk($sformatf("vec%0d_idle", r),  bus.idle,      vt[r].idle);
    end
    clear_src();

    // Backpressure with scoreboard
    sb_on = 1'b1;
    seq = 0;
    for (int c = 0; c < 12; c++) begin
      drive(5, 1'b1, 5'(seq), {4'd5, 28'(seq)});
      seq++;
      tick();
      chk("bp_ready5_alone", bus.src_ready[5], 1'b1);
    end
    saw_low = 1'b0;
    for (int c = 0; c < 20; c++) begin
      for (int unsigned i = 0; i < N; i++) begin
        drive(i, 1'b1, 5'(seq + int'(i)), {4'(i), 28'(seq)});
      end
      seq++;
      tick();
      if (!bus.src_ready[5]) saw_low = 1'b1;
    end
    chk("bp_ready5_falls", saw_low, 1'b1);
    clear_src();
    for (int c = 0; c < 24; c++) tick();
    chk("bp_count", written, pushed);
    leftover = 0;
    for (int unsigned i = 0; i < N; i++) leftover += sbq[i].size();
    chk("bp_leftover", leftover, 0);
    chk("bp_idle", bus.idle, 1'b1);

    // Fairness: sources 0 and 1 always valid
    last = -1;
    for (int c = 0; c < 16; c++) begin
      drive(0, 1'b1, 5'(seq), {4'd0, 28'(seq)});
      drive(1, 1'b1, 5'(seq + 1), {4'd1, 28'(seq)});
      seq++;
      tick();
      if (c >= 1) chk("fair_we", bus.gpr_we, 1'b1);
      if (bus.gpr_we) begin
        int src;
        src = int'(bus.gpr_wdata[31:28]);
        chk("fair_src_range", src < 2, 1'b1);
        if (last >= 0) chk("fair_alt", src, 1 - last);
        last = src;
      end
    end
    clear_src();
    for (int c = 0; c < 8; c++) tick();
    chk("fair_count", written, pushed);
    sb_on = 1'b0;

    // Full FIFO refuses a push in its pop cycle
    reset_pulse();
    drive(0, 1'b1, 5'd1, 32'h100);
    drive(1, 1'b1, 5'd2, 32'h101);
    drive(2, 1'b1, 5'd3, 32'h102);
    tick();
    chk("full_ready2_e1", bus.src_ready[2], 1'b1);
    clear_src();
    drive(2, 1'b1, 5'd4, 32'h200);
    tick();
    chk("full_e2_we", bus.gpr_we, 1'b1);
    chk("full_e2_w", {bus.gpr_waddr, bus.gpr_wdata}, {5'd1, 32'h100});
    chk("full_ready2_e2", bus.src_ready[2], 1'b0);
    drive(2, 1'b1, 5'd31, 32'hBAD0_BAD0);
    tick();
    chk("full_e3_w", {bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata}, {1'b1, 5'd2, 32'h101});
    chk("full_ready2_popcyc", bus.src_ready[2], 1'b0);
    tick();
    chk("full_e4_w", {bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata}, {1'b1, 5'd3, 32'h102});
    chk("full_ready2_e4", bus.src_ready[2], 1'b1);
    clear_src();
    tick();
    chk("full_e5_w", {bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata}, {1'b1, 5'd4, 32'h200});
    tick();
    chk("full_e6_we", bus.gpr_we, 1'b0);
    chk("full_e6_idle", bus.idle, 1'b1);
    tick();
    chk("full_e7_we", bus.gpr_we, 1'b0);

    // Reset mid-stream discards buffered results
    reset_pulse();
    for (int unsigned i = 0; i < 4; i++) drive(i, 1'b1, 5'(10 + i), 32'hC0 + i);
    tick();
    chk("mid_busy", bus.idle, 1'b0);
    clear_src();
    reset = 1'b1;
    tick();
    chk("mid_we", bus.gpr_we, 1'b0);
    chk("mid_idle", bus.idle, 1'b1);
    chk("mid_ready_low", bus.src_ready, 8'h00);
    reset = 1'b0;
    #1;
    chk("mid_ready_high", bus.src_ready, 8'hFF);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mid_no_write", bus.gpr_we, 1'b0);
    end
    chk("mid_idle_end", bus.idle, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter between the functional-unit result buses and the GPR file. It accepts up to eight register results per cycle from the functional units, buffers each in a small per-source FIFO, and drains them through the single GPR write port by round-robin arbitration. It back-pressures any unit whose buffer is full, so no result is ever dropped.

## Interface
Parameters:
- NUM_SRC, 8: number of result sources (functional-unit slots 0..7).
- DEPTH, 2: entries per source FIFO (power of two, ≥2).
- DATA_W, 32: GPR data width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- src_valid  in  NUM_SRC  source i presents a result this cycle.
- src_gpr  in  NUM_SRC×5  destination GPR index per source.
- src_data  in  NUM_SRC×DATA_W  result data per source.
- src_ready  out  NUM_SRC  source i may present a result; transfer = valid & ready.
- gpr_we  out  1  GPR write enable (registered).
- gpr_waddr  out  5  GPR write address (registered).
- gpr_wdata  out  DATA_W  GPR write data (registered).
- idle  out  1  all FIFOs empty and no write in the output register.

## Operation
- Per-source FIFO: push on src_valid[i] & src_ready[i]; src_valid while !src_ready is ignored (no capture).
- src_ready[i] = (count[i] < DEPTH) & !reset; derived from registered count only — a full FIFO refuses a push even in a cycle where it is popped.
- Arbiter: among sources with non-empty FIFO, grant the first at or after rr_ptr (wrapping NUM_SRC-1 → 0). On grant g, pop FIFO g, load {1, gpr, data} of head into output register, rr_ptr ← (g+1) mod NUM_SRC. No candidate: gpr_we ← 0, rr_ptr unchanged, gpr_waddr/gpr_wdata hold previous value.
- Exactly one grant per cycle; the write port never stalls.
- Ordering: per-source FIFO order preserved. No ordering across sources; WAW hazards across units are excluded by the issue stage.
- GPR index 0 is an ordinary register (written like any other).
- idle = all count[i]==0 & !gpr_we.

## Timing
- Reset (sync, active-high): all counts 0, FIFO pointers 0, rr_ptr 0, gpr_we 0, gpr_waddr 0, gpr_wdata 0, src_ready all 0 while reset is high, all 1 in the first cycle after deassertion; idle 1 after first edge with reset.
- Reset mid-operation: buffered results discarded, pending output write cancelled (gpr_we 0 from next cycle).
- Latency: result accepted at edge E0 is eligible in the following cycle; if granted, gpr_we=1 with its data in the cycle after edge E1 (2 edges, minimum).
- Throughput: 1 write/cycle sustained while any FIFO is non-empty.
- Starvation bound: a non-empty source is granted within NUM_SRC cycles.
- src_ready[i] falls in the cycle after the push that fills FIFO i; rises in the cycle after the pop that frees a slot.

## Structure
- Package wb_arb_pkg: typedef Gpr_index (logic[4:0]); struct Wb_entry {Gpr_index gpr; logic[DATA_W-1:0] data;}; constant WB_NUM_SRC = 8.
- Sub-module wb_src_fifo: DEPTH-entry FIFO of Wb_entry with push/pop, count, full/empty; instantiated NUM_SRC times.
- Round-robin pick and output register live in wb_arbiter.

## Test plan
- Single result: src 3 pushes {gpr 7, 0xDEADBEEF} at E0 → gpr_we=1, waddr 7, wdata 0xDEADBEEF after E1; idle returns 1 the cycle after.
- All 8 sources push one result in the same cycle, rr_ptr 0 → writes in source order 0..7 over 8 consecutive cycles, gpr_we continuous, then 0.
- Backpressure: src 5 valid every cycle, others idle, DEPTH 2 → src_ready[5] stays 1 (1 pop/cycle keeps count < 2); then hold sources 0–7 valid every cycle → src 5 sees ready deassert once full, no result lost or duplicated (scoreboard count matches).
- Fairness: sources 0 and 1 continuously valid → grants strictly alternate 0,1,0,1.
- Full refuses push on pop cycle: fill FIFO 2 to DEPTH, keep valid → src_ready[2]=0 in the pop cycle; data offered then is not written.
- Reset mid-stream: 4 results buffered, reset asserted 1 cycle → gpr_we 0 next cycle, none of the 4 written, idle 1, src_ready all 1 after deassertion.
